// File: rtl/sram_pkg.sv
// Shared constants and types for the 1RW/1R parameterised SRAM.
// Contents: default DATA_W / ADDR_W / READ_LAT values and the
// clear-FSM state type used when SRAM_INIT_CLEAR_EN is defined.
package sram_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_READ_LAT = 1;

    // Power-up clear sequencer states
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clr_state_e;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline for one SRAM read port: carries a valid flag and the
// word read from the array, then loads it into the held output register.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (flushes the pipe)
//   in_vld     : a read was accepted on this edge
//   in_data    : array word addressed by that read (pre-write value)
//   dout       : read data, held until the next read completes
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] dout
);

    logic              stg_vld;
    logic [DATA_W-1:0] stg_data;

    // Optional extra stage so the word lands one edge later
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              vld_q;
            logic [DATA_W-1:0] data_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q <= in_vld;
                    if (in_vld) begin
                        data_q <= in_data;
                    end
                end
            end

            assign stg_vld  = vld_q;
            assign stg_data = data_q;
        end else begin : g_lat1
            assign stg_vld  = in_vld;
            assign stg_data = in_data;
        end
    endgenerate

    // Output register only changes when a read completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (stg_vld) begin
            dout <= stg_data;
        end
    end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parameterised SRAM: port 0 read/write with byte mask, port 1 read-only.
// Same-address port 0 write / port 1 read is read-before-write and raises
// a one-cycle collision pulse.
// Build option: define SRAM_INIT_CLEAR_EN to zero the array after reset
// (ready stays low for DEPTH cycles); otherwise ready rises on the first
// edge after reset release and contents start undefined.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   csb0, web0, wmask0      : port 0 select / write enable (active-low), byte mask
//   addr0, din0, dout0      : port 0 address, write data, read data
//   csb1, addr1, dout1      : port 1 select (active-low), address, read data
//   ready                   : accesses are accepted
//   collision               : port 0 write / port 1 read address clash pulse
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned ADDR_W   = DEF_ADDR_W,
    parameter  int unsigned READ_LAT = DEF_READ_LAT,
    localparam int unsigned MASK_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csb0,
    input  logic              web0,
    input  logic [MASK_W-1:0] wmask0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] din0,
    output logic [DATA_W-1:0] dout0,
    input  logic              csb1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] dout1,
    output logic              ready,
    output logic              collision
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    generate
        if (!(READ_LAT == 1 || READ_LAT == 2)) begin : g_bad_lat
            $fatal(1, "sram_1rw1r_param: READ_LAT must be 1 or 2");
        end
        if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
            $fatal(1, "sram_1rw1r_param: DATA_W must be a non-zero multiple of 8");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready_q;
    logic              clr_we_c;
    logic [ADDR_W-1:0] clr_addr_c;
    logic              acc_en;
    logic              wr0_en;
    logic              rd0_en;
    logic              rd1_en;
    logic              coll_q;

`ifdef SRAM_INIT_CLEAR_EN
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Clear FSM state register; ready follows the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= (state_d == RUN);
        end
    end

    // Walk every address once, then run
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Clear write strobe, suppressed on reset edges
    always_comb begin
        clr_we_c   = 1'b0;
        clr_addr_c = clr_addr_q;
        if (state_q == CLEAR && rst_n) begin
            clr_we_c = 1'b1;
        end
    end
`else
    // No clear: accept accesses from the first edge after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign clr_we_c   = 1'b0;
    assign clr_addr_c = '0;
`endif

    // Reset edges never perform accesses, whatever ready held before
    assign acc_en = ready_q & rst_n;
    assign wr0_en = acc_en & ~csb0 & ~web0;
    assign rd0_en = acc_en & ~csb0 &  web0;
    assign rd1_en = acc_en & ~csb1;

    // Array write; reads below see the pre-edge contents
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr_c] <= '0;
        end else if (wr0_en) begin
            for (int i = 0; i < int'(MASK_W); i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
                end
            end
        end
    end

    // A write with an empty mask changes nothing, so it cannot clash
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= wr0_en & (|wmask0) & rd1_en & (addr0 == addr1);
        end
    end

    sram_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd0_en),
        .in_data (mem[addr0]),
        .dout    (dout0)
    );

    sram_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd1_en),
        .in_data (mem[addr1]),
        .dout    (dout1)
    );

    assign ready     = ready_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: two instances (READ_LAT 1 and 2) share one
// stimulus stream; a word-level memory model queues expected read data,
// and a negedge monitor pops and compares it against both instances.
module tb_sram_1rw1r_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned MW    = DW / 8;
`ifdef SRAM_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
    logic [MW-1:0] wmask0 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] din0 = '0;
    logic [DW-1:0] dout0_a, dout1_a, dout0_b, dout1_b;
    logic          ready_a, ready_b, coll_a, coll_b;

    always #5 clk = ~clk;

    sram_1rw1r_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_a), .csb1(csb1), .addr1(addr1),
        .dout1(dout1_a), .ready(ready_a), .collision(coll_a));

    sram_1rw1r_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_b), .csb1(csb1), .addr1(addr1),
        .dout1(dout1_b), .ready(ready_b), .collision(coll_b));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp, input logic [MW-1:0] km);
        logic [DW-1:0] m;
        for (int i = 0; i < int'(MW); i++) m[i*8 +: 8] = {8{km[i]}};
        n_chk++;
        if (((act ^ exp) & m) !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (known bytes %b) t=%0t", nm, act, exp, km, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [MW-1:0] km;
    } rd_t;

    logic [DW-1:0] mdl_mem   [DEPTH] = '{default: '0};
    logic [MW-1:0] mdl_known [DEPTH] = '{default: '0};
    rd_t q0a[$], q1a[$], q0b[$], q1b[$];
    int  cyc = 0;
    bit  started = 1'b0;
    bit  mdl_ready = 1'b0;
    int  clr_cnt = 0;
    bit  exp_coll = 1'b0;
    bit  m_wr, m_r0, m_r1;
    logic [DW-1:0] e0a = '0, e1a = '0, e0b = '0, e1b = '0;
    logic [MW-1:0] k0a = '0, k1a = '0, k0b = '0, k1b = '0;

    function automatic rd_t mk(input int due, input logic [AW-1:0] a);
        rd_t r;
        r.due  = due;
        r.data = mdl_mem[a];
        r.km   = mdl_known[a];
        return r;
    endfunction

    // Per-edge behaviour: reads see the old word, then the write applies
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            started = 1'b1;
            q0a.delete(); q1a.delete(); q0b.delete(); q1b.delete();
            e0a = '0; e1a = '0; e0b = '0; e1b = '0;
            k0a = '1; k1a = '1; k0b = '1; k1b = '1;
            mdl_ready = 1'b0;
            clr_cnt   = 0;
            exp_coll  = 1'b0;
        end else begin
            m_wr = mdl_ready && !csb0 && !web0;
            m_r0 = mdl_ready && !csb0 && web0;
            m_r1 = mdl_ready && !csb1;
            exp_coll = m_wr && m_r1 && (wmask0 != '0) && (addr0 == addr1);
            if (m_r0) begin
                q0a.push_back(mk(cyc, addr0));
                q0b.push_back(mk(cyc + 1, addr0));
            end
            if (m_r1) begin
                q1a.push_back(mk(cyc, addr1));
                q1b.push_back(mk(cyc + 1, addr1));
            end
            if (m_wr) begin
                for (int i = 0; i < int'(MW); i++) begin
                    if (wmask0[i]) begin
                        mdl_mem[addr0][i*8 +: 8] = din0[i*8 +: 8];
                        mdl_known[addr0][i] = 1'b1;
                    end
                end
            end
            if (!mdl_ready) begin
                if (CLR) begin
                    mdl_mem[clr_cnt]   = '0;
                    mdl_known[clr_cnt] = '1;
                    clr_cnt++;
                    if (clr_cnt == int'(DEPTH)) mdl_ready = 1'b1;
                end else begin
                    mdl_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    rd_t r_m;
    always @(negedge clk) begin
        if (started) begin
            while (q0a.size() > 0 && q0a[0].due <= cyc) begin r_m = q0a.pop_front(); e0a = r_m.data; k0a = r_m.km; end
            while (q1a.size() > 0 && q1a[0].due <= cyc) begin r_m = q1a.pop_front(); e1a = r_m.data; k1a = r_m.km; end
            while (q0b.size() > 0 && q0b[0].due <= cyc) begin r_m = q0b.pop_front(); e0b = r_m.data; k0b = r_m.km; end
            while (q1b.size() > 0 && q1b[0].due <= cyc) begin r_m = q1b.pop_front(); e1b = r_m.data; k1b = r_m.km; end
            chk("lat1_dout0", dout0_a, e0a, k0a);
            chk("lat1_dout1", dout1_a, e1a, k1a);
            chk("lat2_dout0", dout0_b, e0b, k0b);
            chk("lat2_dout1", dout1_b, e1b, k1b);
            chk("lat1_collision", DW'(coll_a), DW'(exp_coll), '1);
            chk("lat2_collision", DW'(coll_b), DW'(exp_coll), '1);
            chk("lat1_ready", DW'(ready_a), DW'(mdl_ready), '1);
            chk("lat2_ready", DW'(ready_b), DW'(mdl_ready), '1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic c0, input logic w0, input logic [MW-1:0] m,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d,
                      input logic c1, input logic [AW-1:0] a1);
        csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d;
        csb1 = c1; addr1 = a1;
        @(negedge clk);
    endtask

    task automatic idle();
        op(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    endtask

    task automatic rnd_op();
        op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), MW'($urandom),
           AW'($urandom_range(0, 7)), DW'($urandom),
           1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)));
    endtask

    // Release reset and count edges until ready, with random ignored traffic
    task automatic release_and_wait(input string nm);
        int n = 0;
        rst_n = 1'b1;
        do begin
            rnd_op();
            n++;
        end while (!ready_b && n < int'(DEPTH) + 10);
        chk_int(nm, n, CLR ? int'(DEPTH) : 1);
        idle();
    endtask

    initial begin
        idle();
        repeat (3) idle();
        chk("reset_dout0", dout0_a, '0, '1);
        chk("reset_dout1", dout1_b, '0, '1);
        chk("reset_ready", DW'(ready_a), '0, '1);
        release_and_wait("ready_latency");

        // Masked byte merge
        op(1'b0, 1'b0, 4'hF, 6'h10, 32'hDEADBEEF, 1'b1, '0);
        op(1'b0, 1'b0, 4'h1, 6'h10, 32'h000000AA, 1'b1, '0);
        op(1'b0, 1'b1, '0, 6'h10, '0, 1'b1, '0);
        chk("merge_lat1", dout0_a, 32'hDEADBEAA, '1);
        idle();
        chk("merge_lat2", dout0_b, 32'hDEADBEAA, '1);

        // Empty-mask write is a no-op and leaves dout0 alone
        op(1'b0, 1'b0, 4'h0, 6'h10, 32'hFFFFFFFF, 1'b1, '0);
        chk("nomask_hold", dout0_a, 32'hDEADBEAA, '1);
        op(1'b0, 1'b1, '0, 6'h10, '0, 1'b1, '0);
        idle();
        chk("nomask_lat2", dout0_b, 32'hDEADBEAA, '1);

        // Read-before-write collision
        op(1'b0, 1'b0, 4'hF, 6'h20, 32'h0, 1'b1, '0);
        op(1'b0, 1'b0, 4'hF, 6'h20, 32'h12345678, 1'b0, 6'h20);
        chk("rbw_old_lat1", dout1_a, 32'h0, '1);
        chk("coll_pulse", DW'(coll_a), 32'h1, '1);
        idle();
        chk("rbw_old_lat2", dout1_b, 32'h0, '1);
        chk("coll_one_cycle", DW'(coll_b), 32'h0, '1);
        op(1'b1, 1'b1, '0, '0, '0, 1'b0, 6'h20);
        chk("rbw_new_lat1", dout1_a, 32'h12345678, '1);
        op(1'b0, 1'b1, '0, 6'h20, '0, 1'b0, 6'h20);
        chk("rbw_new_lat2", dout1_b, 32'h12345678, '1);
        chk("no_coll_rd_rd", DW'(coll_a), 32'h0, '1);
        idle();

        // Back-to-back latency-2 reads
        for (int i = 1; i <= 3; i++)
            op(1'b0, 1'b0, 4'hF, AW'(i), DW'(32'h11111111 * i), 1'b1, '0);
        op(1'b1, 1'b1, '0, '0, '0, 1'b0, 6'd1);
        op(1'b1, 1'b1, '0, '0, '0, 1'b0, 6'd2);
        chk("b2b_1", dout1_b, 32'h11111111, '1);
        op(1'b1, 1'b1, '0, '0, '0, 1'b0, 6'd3);
        chk("b2b_2", dout1_b, 32'h22222222, '1);
        idle();
        chk("b2b_3", dout1_b, 32'h33333333, '1);

        // Reset with reads in flight
        op(1'b0, 1'b1, '0, 6'h10, '0, 1'b0, 6'h20);
        rst_n = 1'b0;
        idle();
        chk("rst_flush_lat1_d0", dout0_a, '0, '1);
        chk("rst_flush_lat2_d0", dout0_b, '0, '1);
        chk("rst_flush_lat2_d1", dout1_b, '0, '1);
        idle();
        release_and_wait("ready_after_flush");
        repeat (3) idle();
        chk("no_stale_lat2", dout0_b, '0, '1);

        if (CLR) begin
            op(1'b1, 1'b1, '0, '0, '0, 1'b0, 6'h2A);
            chk("cleared_word", dout1_a, '0, '1);
            // Reset mid-clear restarts from address 0
            rst_n = 1'b0;
            idle();
            rst_n = 1'b1;
            repeat (7) idle();
            rst_n = 1'b0;
            idle();
            release_and_wait("clear_restart");
        end

        repeat (600) rnd_op();
        repeat (3) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter READ_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL derive MASK_W = DATA_W/8, one write-mask bit per byte.
REQ-005 SHALL have ports, with the clock and reset listed first:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- csb0  in  1  port 0 select, active-low.
- web0  in  1  port 0 write enable, active-low.
- wmask0  in  MASK_W  byte write mask, 1 = write byte.
- addr0  in  ADDR_W  port 0 address.
- din0  in  DATA_W  port 0 write data.
- dout0  out  DATA_W  port 0 read data.
- csb1  in  1  port 1 (read-only) select, active-low.
- addr1  in  ADDR_W  port 1 address.
- dout1  out  DATA_W  port 1 read data.
- ready  out  1  memory accepts accesses.
- collision  out  1  one-cycle pulse on a port 0 write / port 1 read address clash.

Function
REQ-006 SHALL sample all inputs on the clk rising edge; no combinational path from input to output.
REQ-007 SHALL write on an edge where ready=1, csb0=0 and web0=0: byte i of mem[addr0] takes din0 byte i only where wmask0[i]=1; other bytes keep their value.
REQ-008 SHALL accept a write with wmask0=0 as a no-op; it SHALL NOT drive dout0.
REQ-009 SHALL treat an edge where ready=1, csb0=0 and web0=1 as a port 0 read; mem[addr0] appears on dout0 READ_LAT cycles after the sampling edge.
REQ-010 SHALL treat an edge where ready=1 and csb1=0 as a port 1 read; mem[addr1] appears on dout1 READ_LAT cycles after the sampling edge.
REQ-011 SHALL hold each dout at its last read value when no read completes; a write SHALL NOT disturb dout0.
REQ-012 SHALL use read-before-write when a port 0 write and a port 1 read target the same address on the same edge: dout1 returns the old word, and the write completes.
REQ-013 SHALL pulse collision high for exactly one cycle, starting the cycle after the REQ-012 edge; it SHALL NOT pulse when the addresses differ or on read/read to the same address.
REQ-014 SHALL ignore all accesses while ready=0: no writes, no new reads, no collision.
REQ-015 SHALL, when READ_LAT=2, accept back-to-back reads every cycle with no bubbles; in-flight reads SHALL complete in order.

Reset
REQ-016 SHALL, while rst_n=0 at an edge, set dout0=0, dout1=0 and collision=0, and flush the read pipelines so that no in-flight read completes.
REQ-017 SHALL leave memory contents unchanged by reset unless REQ-019 applies.

Configuration
REQ-018 SHALL use the macro SRAM_INIT_CLEAR_EN.
REQ-019 With SRAM_INIT_CLEAR_EN defined:
- After reset, an FSM SHALL enter state CLEAR with ready=0 and write all-zero to addresses 0..DEPTH-1, one per cycle.
- In the cycle after address DEPTH-1 is written, the FSM SHALL move to state RUN and ready SHALL go to 1.
- Clearing takes exactly DEPTH cycles.
- A reset during CLEAR SHALL restart clearing from address 0.
REQ-020 Without SRAM_INIT_CLEAR_EN defined:
- ready SHALL be 1 from the first edge after reset is released.
- There SHALL be no clear FSM.
- Initial memory contents are undefined (X in simulation).

Structure
REQ-021 SHALL put in package sram_pkg:
- default constants for DATA_W, ADDR_W and READ_LAT;
- the state typedef for the clear FSM (CLEAR, RUN).
REQ-022 SHALL instantiate sub-module sram_rd_pipe (parameters DATA_W, READ_LAT; carries valid and data) once per read port.
REQ-023 SHALL stop elaboration with a fatal error if READ_LAT is not 1 or 2, or if DATA_W is not a multiple of 8.

Verification
REQ-024 Write 0xDEADBEEF to addr 0x10 with wmask0=0xF, then write 0x000000AA with wmask0=0x1, then read on port 0 -> dout0=0xDEADBEAA after READ_LAT cycles.
REQ-025 Port 0 write of 0x12345678 to 0x20 while port 1 reads 0x20 (old word 0x0) -> dout1=0x0 and a one-cycle collision pulse; the next port 1 read of 0x20 -> 0x12345678.
REQ-026 READ_LAT=2, port 1 reads of addresses 1, 2, 3 on consecutive cycles -> dout1 shows mem[1], mem[2], mem[3] on consecutive cycles, starting 2 cycles after the first read.
REQ-027 SRAM_INIT_CLEAR_EN, ADDR_W=4 -> ready=0 for 16 cycles after reset release, then 1; a read of any address -> 0.
REQ-028 SRAM_INIT_CLEAR_EN, assert rst_n=0 at clear address 7, then release -> clearing restarts at address 0; ready rises 16 cycles after release.
REQ-029 Assert rst_n=0 with a read in flight -> dout0=dout1=0, and no stale read appears after reset is released.
